// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter placing the DCJ11 port and the Apple II
// loader port in front of the PSRAM controller. The Apple II port is served
// only when the macro A2_DMA_EN is defined; otherwise its inputs are ignored
// and the DCJ11 port owns the memory.
module ram_arbiter #(
    parameter logic [21:0] HIMEM   = 22'o17757777,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk_x3,
    input  logic        rst,
    input  logic        mem_init,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        a2_req,
    input  logic        a2_we,
    input  logic        a2_byte,
    input  logic [21:0] a2_addr,
    input  logic [15:0] a2_wdata,
    output logic [15:0] a2_rdata,
    output logic        a2_ack,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_done,
    output logic        err,
    output logic        arb_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_A2  = 1'b1;
    localparam int   CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic             a2_req_e, a2_we_e, a2_byte_e;
    logic [21:0]      a2_addr_e;
    logic [15:0]      a2_wdata_e;
    logic             win, win_we, win_byte, win_oor;
    logic [21:0]      win_addr;
    logic [15:0]      win_wdata;
    logic             grant, timeout_hit, finish;
    logic             fin_port, fin_we;
    logic [15:0]      fin_rdata;
    logic             last_grant, grant_q, we_q, byte_q;
    logic [CNT_W-1:0] wait_cnt;

`ifdef A2_DMA_EN
    assign a2_req_e   = a2_req;
    assign a2_we_e    = a2_we;
    assign a2_byte_e  = a2_byte;
    assign a2_addr_e  = a2_addr;
    assign a2_wdata_e = a2_wdata;
`else
    // Apple II port disabled: it never requests, so the DCJ11 always wins.
    logic unused_a2;
    assign a2_req_e   = 1'b0;
    assign a2_we_e    = 1'b0;
    assign a2_byte_e  = 1'b0;
    assign a2_addr_e  = '0;
    assign a2_wdata_e = '0;
    assign unused_a2  = ^{a2_req, a2_we, a2_byte, a2_addr, a2_wdata};
`endif

    // Round-robin pick: a lone request wins, a tie goes to the port not served last.
    always_comb begin
        win       = a2_req_e && (!cpu_req || last_grant == PORT_CPU);
        win_we    = win ? a2_we_e    : cpu_we;
        win_byte  = win ? a2_byte_e  : cpu_byte;
        win_addr  = win ? a2_addr_e  : cpu_addr;
        win_wdata = win ? a2_wdata_e : cpu_wdata;
        win_oor   = win_addr > HIMEM;
    end

    // State register.
    always_ff @(posedge clk_x3) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; out-of-range accesses skip straight to DONE.
    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_init && !mem_busy && (cpu_req || a2_req_e)) begin
                    grant     = 1'b1;
                    state_nxt = win_oor ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mem_done) begin
                    state_nxt = DONE;
                end else if (wait_cnt == CNT_MAX) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion bookkeeping: which port finishes and what read data it gets.
    always_comb begin
        finish   = (state_nxt == DONE) && (state != DONE);
        fin_port = grant ? win    : grant_q;
        fin_we   = grant ? win_we : we_q;
        if (timeout_hit)        fin_rdata = 16'hFFFF;
        else if (state == IDLE) fin_rdata = 16'h0000;
        else                    fin_rdata = mem_rdata;
    end

    // Registered strobes, acks, latched command and per-port read data.
    always_ff @(posedge clk_x3) begin
        if (rst) begin
            last_grant <= PORT_A2;
            grant_q    <= PORT_CPU;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            wait_cnt   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_byte   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            a2_ack     <= 1'b0;
            err        <= 1'b0;
            arb_busy   <= 1'b0;
            cpu_rdata  <= '0;
            a2_rdata   <= '0;
        end else begin
            mem_read  <= (state == ISSUE) && !we_q;
            mem_write <= (state == ISSUE) && we_q;
            mem_byte  <= (state == ISSUE) && byte_q;
            arb_busy  <= state_nxt != IDLE;
            cpu_ack   <= finish && (fin_port == PORT_CPU);
            a2_ack    <= finish && (fin_port == PORT_A2);
            err       <= timeout_hit;
            wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (grant) begin
                grant_q <= win;
                we_q    <= win_we;
                byte_q  <= win_byte;
                if (!win_oor) begin
                    mem_addr  <= win_addr;
                    mem_wdata <= win_wdata;
                end
            end
            if (state == DONE) last_grant <= grant_q;
            if (finish && (timeout_hit || !fin_we)) begin
                if (fin_port == PORT_CPU) cpu_rdata <= fin_rdata;
                else                      a2_rdata  <= fin_rdata;
            end
        end
    end

endmodule
